res_station: RTL and testbench

RES_STATION -- requirements
Module: res_station

---
 rtl/res_station_pkg.sv | 40 ++++
 rtl/rs_operand.sv | 78 +++++++
 rtl/res_station.sv | 145 ++++++++++++++
 tb/tb_res_station.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/res_station_pkg.sv
// ---------------------------------------------------------------------------
// tomasula_types -- types shared by the out-of-order issue logic.
//
// Contents:
//   ROB_TAG_W   : width of a reorder-buffer tag (8-entry ROB)
//   alu_ops     : ALU operation encoding
//   ctl_word    : control bundle carried with an issued instruction
//   rs_state_t  : reservation-station state encoding
// ---------------------------------------------------------------------------
package tomasula_types;

  localparam int ROB_TAG_W = 3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ops;

  typedef struct packed {
    alu_ops      op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] src2_data;
  } ctl_word;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } rs_state_t;

endpackage

// File: rtl/rs_operand.sv
// ---------------------------------------------------------------------------
// rs_operand -- one source operand slot of a reservation station.
//
// Holds busy flag, producer tag and operand value. While busy it snoops the
// common data bus and captures the broadcast value on a tag match. A load
// that coincides with a matching broadcast takes the bus value directly so
// the wakeup is not lost.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture a new operand (already gated to IDLE by parent)
//   clear           : squash; drops any pending wait on the bus
//   busy_in/tag_in/data_in : incoming operand from dispatch
//   cdb_valid/cdb_tag/cdb_data : common data bus
//   busy, tag, data : stored operand state
//   avail_next      : operand will hold a valid value after this edge
// ---------------------------------------------------------------------------
module rs_operand
  import tomasula_types::*;
#(
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             busy_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [31:0]      data_in,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             busy,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      data,
  output logic             avail_next
);

  logic busy_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [31:0] data_reg;
  logic snoop_hit;
  logic load_hit;

  // Wakeup of the stored operand, and of the operand arriving this cycle.
  assign snoop_hit = busy_reg && cdb_valid && (cdb_tag == tag_reg);
  assign load_hit  = busy_in && cdb_valid && (cdb_tag == tag_in);

  // Only meaningful while not loading; the parent consults it in WAIT.
  assign avail_next = !busy_reg || snoop_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 1'b0;
      tag_reg  <= '0;
      data_reg <= '0;
    end else if (clear) begin
      busy_reg <= 1'b0;
    end else if (load) begin
      tag_reg <= tag_in;
      if (load_hit) begin
        busy_reg <= 1'b0;
        data_reg <= cdb_data;
      end else begin
        busy_reg <= busy_in;
        data_reg <= data_in;
      end
    end else if (snoop_hit) begin
      busy_reg <= 1'b0;
      data_reg <= cdb_data;
    end
  end

  assign busy = busy_reg;
  assign tag  = tag_reg;
  assign data = data_reg;

endmodule

// File: rtl/res_station.sv
// ---------------------------------------------------------------------------
// res_station -- single-entry reservation station in front of an ALU.
//
// IDLE accepts one instruction, WAIT collects outstanding operands from the
// common data bus, READY presents the instruction to the ALU until it is
// accepted. A flush squashes the held instruction from any state.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   load, ctl_i, rob_tag_i    : allocation from the issue queue
//   src{1,2}_busy_i/_tag_i/_data_i : source operands (value or producer tag)
//   cdb_valid, cdb_tag, cdb_data   : common data bus
//   flush                     : branch-mispredict squash
//   empty                     : station free (registered IDLE)
//   alu_valid, alu_ready      : ALU issue handshake
//   alu_op, alu_a, alu_b, alu_funct3, alu_funct7, alu_tag : ALU request
// ---------------------------------------------------------------------------
module res_station
  import tomasula_types::*;
#(
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  ctl_word          ctl_i,
  input  logic [TAG_W-1:0] rob_tag_i,
  input  logic             src1_busy_i,
  input  logic             src2_busy_i,
  input  logic [TAG_W-1:0] src1_tag_i,
  input  logic [TAG_W-1:0] src2_tag_i,
  input  logic [31:0]      src1_data_i,
  input  logic [31:0]      src2_data_i,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             flush,
  output logic             empty,
  output logic             alu_valid,
  input  logic             alu_ready,
  output alu_ops           alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_funct3,
  output logic             alu_funct7,
  output logic [TAG_W-1:0] alu_tag
);

  rs_state_t state_reg;
  ctl_word ctl_reg;
  logic [TAG_W-1:0] rob_tag_reg;

  logic accept;
  logic src1_busy, src2_busy;
  logic [TAG_W-1:0] src1_tag, src2_tag;
  logic [31:0] src1_data, src2_data;
  logic src1_avail_next, src2_avail_next;

  // The issue stage has already folded any immediate into src2_data_i, so the
  // copy inside the control word is carried but not consumed here.
  logic unused_ctl_src2;
  logic unused_src_tags;
  assign unused_ctl_src2 = ^ctl_reg.src2_data;
  assign unused_src_tags = ^{src1_busy, src2_busy, src1_tag, src2_tag};

  // Flush wins over a coinciding load so nothing is captured into a squashed slot.
  assign accept = load && (state_reg == IDLE) && !flush;

  rs_operand #(.TAG_W(TAG_W)) u_src1 (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .clear      (flush),
    .busy_in    (src1_busy_i),
    .tag_in     (src1_tag_i),
    .data_in    (src1_data_i),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .busy       (src1_busy),
    .tag        (src1_tag),
    .data       (src1_data),
    .avail_next (src1_avail_next)
  );

  rs_operand #(.TAG_W(TAG_W)) u_src2 (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .clear      (flush),
    .busy_in    (src2_busy_i),
    .tag_in     (src2_tag_i),
    .data_in    (src2_data_i),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .busy       (src2_busy),
    .tag        (src2_tag),
    .data       (src2_data),
    .avail_next (src2_avail_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ctl_reg     <= '0;
      rob_tag_reg <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) begin
            ctl_reg     <= ctl_i;
            rob_tag_reg <= rob_tag_i;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          // A wakeup on the bus this cycle lands in the operand register at
          // the same edge, so READY can follow immediately.
          if (src1_avail_next && src2_avail_next) begin
            state_reg <= READY;
          end
        end
        READY: begin
          if (alu_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign empty      = (state_reg == IDLE);
  assign alu_valid  = (state_reg == READY);
  assign alu_op     = ctl_reg.op;
  assign alu_funct3 = ctl_reg.funct3;
  assign alu_funct7 = ctl_reg.funct7;
  assign alu_a      = alu_valid ? src1_data : '0;
  assign alu_b      = alu_valid ? src2_data : '0;
  assign alu_tag    = alu_valid ? rob_tag_reg : '0;

endmodule

// File: tb/tb_res_station.sv
// ---------------------------------------------------------------------------
// tb_res_station -- self-checking bench for res_station.
// ---------------------------------------------------------------------------
module tb_res_station;
  import tomasula_types::*;

  localparam int TAG_W = ROB_TAG_W;

  logic             clk;
  logic             rst;
  logic             load;
  ctl_word          ctl_i;
  logic [TAG_W-1:0] rob_tag_i;
  logic             src1_busy_i, src2_busy_i;
  logic [TAG_W-1:0] src1_tag_i, src2_tag_i;
  logic [31:0]      src1_data_i, src2_data_i;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             flush;
  logic             empty;
  logic             alu_valid;
  logic             alu_ready;
  alu_ops           alu_op;
  logic [31:0]      alu_a, alu_b;
  logic [2:0]       alu_funct3;
  logic             alu_funct7;
  logic [TAG_W-1:0] alu_tag;

  res_station #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .ctl_i       (ctl_i),
    .rob_tag_i   (rob_tag_i),
    .src1_busy_i (src1_busy_i),
    .src2_busy_i (src2_busy_i),
    .src1_tag_i  (src1_tag_i),
    .src2_tag_i  (src2_tag_i),
    .src1_data_i (src1_data_i),
    .src2_data_i (src2_data_i),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .flush       (flush),
    .empty       (empty),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_funct3  (alu_funct3),
    .alu_funct7  (alu_funct7),
    .alu_tag     (alu_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    alu_ops           op;
    logic [2:0]       f3;
    logic             f7;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0]      s1;
    logic [31:0]      s2;
    alu_ops           op;
    logic [2:0]       f3;
    logic             f7;
    logic [TAG_W-1:0] tag;
    logic [31:0]      want_a;
    logic [31:0]      want_b;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
    end
  endtask

  task automatic check_outputs(input string name, input exp_t e);
    check({name, "_a"},   alu_a, e.a);
    check({name, "_b"},   alu_b, e.b);
    check({name, "_op"},  32'(alu_op), 32'(e.op));
    check({name, "_f3"},  32'(alu_funct3), 32'(e.f3));
    check({name, "_f7"},  32'(alu_funct7), 32'(e.f7));
    check({name, "_tag"}, 32'(alu_tag), 32'(e.tag));
  endtask

  task automatic idle_in();
    load        = 1'b0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_data    = '0;
    flush       = 1'b0;
    alu_ready   = 1'b0;
  endtask

  task automatic drive_load(input logic b1, input logic [TAG_W-1:0] t1, input logic [31:0] d1,
                            input logic b2, input logic [TAG_W-1:0] t2, input logic [31:0] d2,
                            input alu_ops op, input logic [2:0] f3, input logic f7,
                            input logic [TAG_W-1:0] tag);
    load        = 1'b1;
    src1_busy_i = b1;
    src1_tag_i  = t1;
    src1_data_i = d1;
    src2_busy_i = b2;
    src2_tag_i  = t2;
    src2_data_i = d2;
    ctl_i       = '{op: op, funct3: f3, funct7: f7, src2_data: d2};
    rob_tag_i   = tag;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input alu_ops op,
                          input logic [2:0] f3, input logic f7, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.f3 = f3; e.f7 = f7; e.tag = tag;
    sb.push_back(e);
  endtask

  // Called at a negedge where READY is expected: pop, compare, then accept.
  task automatic handshake(input string name);
    exp_t e;
    check({name, "_valid"}, 32'(alu_valid), 32'd1);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: got empty scoreboard expected pending entry", name);
    end else begin
      e = sb.pop_front();
      check_outputs(name, e);
      $display("txn %s: a=0x%08h b=0x%08h op=%0d tag=%0d", name, alu_a, alu_b, alu_op, alu_tag);
    end
    alu_ready = 1'b1;
    #1;
    check({name, "_empty_nobypass"}, 32'(empty), 32'd0);
    @(negedge clk);
    alu_ready = 1'b0;
    check({name, "_empty_after"}, 32'(empty), 32'd1);
    check({name, "_valid_after"}, 32'(alu_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0007, ALU_ADD, 3'd0, 1'b0, 3'd3, 32'h0000_0005, 32'h0000_0007};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, ALU_SUB, 3'd0, 1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, ALU_XOR, 3'd4, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h8000_0000, 32'h1234_5678, ALU_SRA, 3'd5, 1'b1, 3'd6, 32'h8000_0000, 32'h1234_5678};

    rst = 1'b1;
    idle_in();
    drive_load(1'b0, '0, '0, 1'b0, '0, '0, ALU_ADD, 3'd0, 1'b0, '0);
    load = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_valid", 32'(alu_valid), 32'd0);
    check_outputs("rst", '{32'h0, 32'h0, ALU_ADD, 3'd0, 1'b0, '0});
    rst = 1'b0;
    @(negedge clk);

    // Both operands ready at load: READY two edges later.
    for (int i = 0; i < 4; i++) begin
      drive_load(1'b0, 3'd1, vecs[i].s1, 1'b0, 3'd2, vecs[i].s2,
                 vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].tag);
      push_exp(vecs[i].want_a, vecs[i].want_b, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].tag);
      @(negedge clk);
      idle_in();
      check($sformatf("vec%0d_lat1_valid", i), 32'(alu_valid), 32'd0);
      check($sformatf("vec%0d_lat1_empty", i), 32'(empty), 32'd0);
      check($sformatf("vec%0d_lat1_a", i), alu_a, 32'd0);
      @(negedge clk);
      handshake($sformatf("vec%0d", i));
    end

    // src1 waits on tag 2; src2 ready but carries tag 2 too (must be ignored).
    drive_load(1'b1, 3'd2, 32'h0000_AAAA, 1'b0, 3'd2, 32'h0000_0003, ALU_OR, 3'd6, 1'b0, 3'd4);
    push_exp(32'hDEAD_BEEF, 32'h0000_0003, ALU_OR, 3'd6, 1'b0, 3'd4);
    @(negedge clk);
    idle_in();
    check("wake_c1_valid", 32'(alu_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 32'h0000_1111;
    @(negedge clk);
    idle_in();
    check("wake_c2_valid", 32'(alu_valid), 32'd0);
    drive_load(1'b0, 3'd0, 32'h0BAD_0BAD, 1'b0, 3'd0, 32'h0BAD_0BAD, ALU_SLL, 3'd1, 1'b1, 3'd1);
    @(negedge clk);
    idle_in();
    check("wake_c3_valid", 32'(alu_valid), 32'd0);
    check("wake_c3_empty", 32'(empty), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_in();
    handshake("wake");

    // Load coinciding with the matching broadcast for src2.
    drive_load(1'b0, 3'd0, 32'h0000_0009, 1'b1, 3'd5, 32'h0000_0000, ALU_AND, 3'd7, 1'b0, 3'd1);
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 32'h0000_0010;
    push_exp(32'h0000_0009, 32'h0000_0010, ALU_AND, 3'd7, 1'b0, 3'd1);
    @(negedge clk);
    idle_in();
    check("bypass_c1_valid", 32'(alu_valid), 32'd0);
    @(negedge clk);
    handshake("bypass");

    // READY held with alu_ready low for three cycles.
    drive_load(1'b0, 3'd0, 32'h0000_0021, 1'b0, 3'd0, 32'h0000_0042, ALU_SLT, 3'd2, 1'b0, 3'd2);
    push_exp(32'h0000_0021, 32'h0000_0042, ALU_SLT, 3'd2, 1'b0, 3'd2);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("hold%0d_valid", c), 32'(alu_valid), 32'd1);
      check($sformatf("hold%0d_empty", c), 32'(empty), 32'd0);
      check_outputs($sformatf("hold%0d", c), sb[0]);
      @(negedge clk);
    end
    handshake("hold");

    // Flush in WAIT alongside a matching broadcast.
    drive_load(1'b1, 3'd1, 32'h0, 1'b0, 3'd0, 32'h0000_0004, ALU_ADD, 3'd0, 1'b0, 3'd3);
    @(negedge clk);
    idle_in();
    check("flush_wait_empty0", 32'(empty), 32'd0);
    flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h0000_0055;
    @(negedge clk);
    idle_in();
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_valid", 32'(alu_valid), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("flush_quiet%0d", c), 32'(alu_valid), 32'd0);
    end

    // Flush overrides a load in IDLE.
    drive_load(1'b0, 3'd0, 32'h1, 1'b0, 3'd0, 32'h2, ALU_ADD, 3'd0, 1'b0, 3'd2);
    flush = 1'b1;
    @(negedge clk);
    idle_in();
    check("flush_load_empty", 32'(empty), 32'd1);
    @(negedge clk);
    check("flush_load_valid", 32'(alu_valid), 32'd0);

    // Asynchronous reset while READY.
    drive_load(1'b0, 3'd0, 32'h0000_0077, 1'b0, 3'd0, 32'h0000_0088, ALU_SUB, 3'd3, 1'b1, 3'd5);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    check("arst_pre_valid", 32'(alu_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(alu_valid), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check_outputs("arst", '{32'h0, 32'h0, ALU_ADD, 3'd0, 1'b0, '0});
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("arst_quiet%0d_valid", c), 32'(alu_valid), 32'd0);
      check($sformatf("arst_quiet%0d_empty", c), 32'(empty), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
